// File: rtl/text_pkg.sv
// Shared constants and types for the tiled text overlay.
package text_pkg;

  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 16;

  localparam logic [6:0] CHAR_BLANK = 7'h00;
  localparam int unsigned ATTR_BLINK_BIT = 3;

  // Palette index -> 12-bit RGB
  localparam logic [11:0] PALETTE [8] = '{
    12'hFFF, // white
    12'hF00, // red
    12'h0F0, // green
    12'h00F, // blue
    12'hFF0, // yellow
    12'h0FF, // cyan
    12'hF0F, // magenta
    12'h888  // grey
  };

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port character/attribute buffer: one write port, one registered
// read port. A read of the cell being written returns the old contents.
module tile_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 11,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Storage array write; no reset so it maps onto block/distributed RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; nonblocking update gives read-before-write ordering
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/text_overlay.sv
// Tile-based text renderer: COLS x ROWS character buffer drawn through the
// external ascii_rom at 2^SCALE_LOG2 scale with a fixed 3-cycle pixel latency.
module text_overlay
  import text_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 32,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned CW = $clog2(COLS),
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_col,
  input  logic [RW-1:0] wr_row,
  input  logic [6:0]    wr_char,
  input  logic [3:0]    wr_attr,
  output logic          busy,
  output logic [10:0]   rom_addr,
  input  logic [7:0]    rom_data,
  output logic          text_on,
  output logic [11:0]   text_rgb
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned REG_W = (COLS * GLYPH_W) << SCALE_LOG2;
  localparam int unsigned REG_H = (ROWS * GLYPH_H) << SCALE_LOG2;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          clearing;

  // Clear/run state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: sweep every cell once after reset, then run
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(CELLS - 1)) begin
          state_d = StRun;
        end
      end
      default: ;
    endcase
  end

  assign clearing = (state_q == StClear);
  assign busy     = clearing;

  // Blink timebase; keeps counting through the clear sweep
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  // Frame-tick divider toggling the blink phase every BLINK_FRAMES ticks
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 0: region decode and buffer address
  logic          s0_on;
  logic [9:0]    dx, dy, sx, sy;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [AW-1:0] rd_addr, wr_addr, ram_waddr;
  logic [10:0]   ram_wdata, ram_rdata;
  logic          ram_we;
  logic          unused_bits;

  assign s0_on = (32'(x) >= X0) && (32'(x) < X0 + REG_W) &&
                 (32'(y) >= Y0) && (32'(y) < Y0 + REG_H) &&
                 video_on && !clearing;

  assign dx     = x - 10'(X0);
  assign dy     = y - 10'(Y0);
  assign sx     = dx >> SCALE_LOG2;
  assign sy     = dy >> SCALE_LOG2;
  assign rd_col = sx[CW+2:3];
  assign rd_row = sy[RW+3:4];
  // COLS is a power of two, so {row, col} is row*COLS+col
  assign rd_addr = AW'({rd_row, rd_col});
  assign wr_addr = AW'({wr_row, wr_col});
  // High offset bits only matter to the region compare above
  assign unused_bits = ^{sx[9:CW+3], sy[9:RW+4]};

  assign ram_we    = clearing | wr_en;
  assign ram_waddr = clearing ? clr_ptr_q : wr_addr;
  assign ram_wdata = clearing ? {CHAR_BLANK, 4'h0} : {wr_char, wr_attr};

  tile_ram #(
    .Depth (CELLS),
    .Width (11)
  ) u_tile_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (rd_addr),
    .rdata   (ram_rdata)
  );

  // Stage 1/2 side-band: flags travelling alongside buffer and ROM data
  logic       s1_on, s2_on;
  logic [3:0] s1_glyph_row;
  logic [2:0] s1_bit, s2_bit;
  logic [3:0] s2_attr;

  // Delay region flag and glyph coordinates to match buffer/ROM latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_on        <= 1'b0;
      s1_glyph_row <= '0;
      s1_bit       <= '0;
      s2_on        <= 1'b0;
      s2_bit       <= '0;
      s2_attr      <= '0;
    end else begin
      s1_on        <= s0_on;
      s1_glyph_row <= sy[3:0];
      s1_bit       <= sx[2:0];
      s2_on        <= s1_on;
      s2_bit       <= s1_bit;
      s2_attr      <= ram_rdata[3:0];
    end
  end

  // Buffer output is already registered, so rom_addr is a clean stage-1 value
  assign rom_addr = {ram_rdata[10:4], s1_glyph_row};

  // Stage 2: pick the glyph bit (bit 7 is leftmost) and resolve colour
  logic        pix, hidden;
  logic        text_on_q;
  logic [11:0] text_rgb_d, text_rgb_q;

  assign pix    = rom_data[3'd7 - s2_bit];
  assign hidden = s2_attr[ATTR_BLINK_BIT] && !blink_phase_q;

  // Output colour select
  always_comb begin
    text_rgb_d = 12'h000;
    if (s2_on && pix && !hidden) begin
      text_rgb_d = PALETTE[s2_attr[2:0]];
    end
  end

  // Stage 3: registered outputs to the pixel mux
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      text_on_q  <= 1'b0;
      text_rgb_q <= 12'h000;
    end else begin
      text_on_q  <= s2_on;
      text_rgb_q <= text_rgb_d;
    end
  end

  assign text_on  = text_on_q;
  assign text_rgb = text_rgb_q;

endmodule
